// File: rtl/sch_pkg.sv
// Shared definitions for the tile scheduler controller: FSM state codes,
// tile_loc bit positions and the default dimension-field width.
package sch_pkg;

   localparam int DIM_WIDTH_DEF = 15;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_BUF = 3'd1;
   localparam logic [2:0] ST_START    = 3'd2;
   localparam logic [2:0] ST_RUN      = 3'd3;
   localparam logic [2:0] ST_NEXT     = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   // tile_loc bit positions
   localparam int LOC_TOP = 0;
   localparam int LOC_BOT = 1;

endpackage

// File: rtl/tile_geom_calc.sv
// Combinational output-height calculation for one row tile:
// out_h = in_h - (ksize-1) + pad on each image edge the tile touches,
// clamped to 0 when the kernel does not fit.
module tile_geom_calc
   import sch_pkg::*;
#(
   parameter int DIM_WIDTH = DIM_WIDTH_DEF
) (
   input  logic [DIM_WIDTH-1:0] i_in_h,
   input  logic [3:0]           i_ksize,
   input  logic                 i_top,
   input  logic                 i_bot,
   output logic [DIM_WIDTH-1:0] o_out_h
);

   logic [DIM_WIDTH:0] w_pad;
   logic [DIM_WIDTH:0] w_sum;
   logic [DIM_WIDTH:0] w_sub;
   logic [DIM_WIDTH:0] w_diff;

   // Add padding first, then compare against ksize-1 so the clamp needs no sign bit
   always_comb begin
      w_pad  = {{(DIM_WIDTH-2){1'b0}}, i_ksize[3:1]};
      w_sum  = {1'b0, i_in_h} + (i_top ? w_pad : '0) + (i_bot ? w_pad : '0);
      w_sub  = (i_ksize == 4'd0) ? '0 : {{(DIM_WIDTH-3){1'b0}}, i_ksize - 4'd1};
      w_diff = w_sum - w_sub;
      if (w_sum < w_sub) begin
         o_out_h = '0;
      end else if (w_diff[DIM_WIDTH]) begin
         // only reachable with even kernels on a full-height tile
         o_out_h = '1;
      end else begin
         o_out_h = w_diff[DIM_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/tile_sch_ctrl.sv
// Layer-level row-tile scheduler: walks a layer tile by tile, waiting for the
// loader's buffer bank, issuing one tile-start pulse per tile and ping-ponging
// the buffer bank select. Optional cycle counter: TILE_SCH_CTRL_PERF_CNT_EN.
module tile_sch_ctrl
   import sch_pkg::*;
#(
   parameter int DIM_WIDTH      = DIM_WIDTH_DEF,
   parameter int TILE_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      layer_start,
   input  logic [3:0]                cfg_ksize,
   input  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles,
   input  logic [DIM_WIDTH-1:0]      cfg_tile_in_h,
   input  logic [DIM_WIDTH-1:0]      cfg_last_in_h,
   input  logic [DIM_WIDTH-1:0]      cfg_in_w,
   input  logic [DIM_WIDTH-1:0]      cfg_out_w,
   input  logic [DIM_WIDTH-1:0]      cfg_in_c,
   input  logic [DIM_WIDTH-1:0]      cfg_out_c,
   input  logic                      buf_rdy,
   input  logic                      tile_done,
   output logic                      ctrl2sch_tile_start,
   output logic                      stack_switch,
   output logic [3:0]                tile_loc,
   output logic [3:0]                ksize,
   output logic [DIM_WIDTH-1:0]      tile_in_h,
   output logic [DIM_WIDTH-1:0]      tile_out_h,
   output logic [DIM_WIDTH-1:0]      tile_in_w,
   output logic [DIM_WIDTH-1:0]      tile_out_w,
   output logic [DIM_WIDTH-1:0]      tile_in_c,
   output logic [DIM_WIDTH-1:0]      tile_out_c,
   output logic                      busy,
   output logic                      layer_done
`ifdef TILE_SCH_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]               perf_cycles
`endif
);

   logic [2:0]                r_state;
   logic [2:0]                w_state_nxt;
   logic [TILE_CNT_WIDTH-1:0] r_idx;
   logic [TILE_CNT_WIDTH-1:0] r_last_idx;
   logic [DIM_WIDTH-1:0]      r_cfg_tile_in_h;
   logic [DIM_WIDTH-1:0]      r_cfg_last_in_h;
   logic [3:0]                r_ksize;
   logic [DIM_WIDTH-1:0]      r_in_w;
   logic [DIM_WIDTH-1:0]      r_out_w;
   logic [DIM_WIDTH-1:0]      r_in_c;
   logic [DIM_WIDTH-1:0]      r_out_c;
   logic [1:0]                r_tile_loc;
   logic [DIM_WIDTH-1:0]      r_tile_in_h;
   logic [DIM_WIDTH-1:0]      r_tile_out_h;
   logic                      r_start;
   logic                      r_sw;
   logic                      r_busy;
   logic                      r_layer_done;

   logic                      w_accept;
   logic                      w_is_first;
   logic                      w_is_last;
   logic [DIM_WIDTH-1:0]      w_in_h;
   logic [DIM_WIDTH-1:0]      w_out_h;

   assign w_accept   = (r_state == ST_IDLE) && layer_start;
   assign w_is_first = (r_idx == '0);
   assign w_is_last  = (r_idx == r_last_idx);
   assign w_in_h     = w_is_last ? r_cfg_last_in_h : r_cfg_tile_in_h;

   tile_geom_calc #(
      .DIM_WIDTH (DIM_WIDTH)
   ) u_geom (
      .i_in_h  (w_in_h),
      .i_ksize (r_ksize),
      .i_top   (w_is_first),
      .i_bot   (w_is_last),
      .o_out_h (w_out_h)
   );

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (layer_start) w_state_nxt = ST_WAIT_BUF;
         ST_WAIT_BUF: if (buf_rdy) w_state_nxt = ST_START;
         ST_START:    w_state_nxt = ST_RUN;
         ST_RUN:      if (tile_done) w_state_nxt = ST_NEXT;
         ST_NEXT:     w_state_nxt = w_is_last ? ST_DONE : ST_WAIT_BUF;
         ST_DONE:     w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   // State register; status outputs decoded from the next state so they are registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_busy       <= 1'b0;
         r_start      <= 1'b0;
         r_layer_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_start      <= (w_state_nxt == ST_START);
         r_layer_done <= (w_state_nxt == ST_DONE);
      end
   end

   // Latch the layer configuration when a layer is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ksize         <= '0;
         r_last_idx      <= '0;
         r_cfg_tile_in_h <= '0;
         r_cfg_last_in_h <= '0;
         r_in_w          <= '0;
         r_out_w         <= '0;
         r_in_c          <= '0;
         r_out_c         <= '0;
      end else if (w_accept) begin
         r_ksize         <= cfg_ksize;
         // a tile count of 0 behaves as a single tile
         r_last_idx      <= (cfg_num_tiles == '0) ? '0 : cfg_num_tiles - TILE_CNT_WIDTH'(1);
         r_cfg_tile_in_h <= cfg_tile_in_h;
         r_cfg_last_in_h <= cfg_last_in_h;
         r_in_w          <= cfg_in_w;
         r_out_w         <= cfg_out_w;
         r_in_c          <= cfg_in_c;
         r_out_c         <= cfg_out_c;
      end
   end

   // Tile index and buffer bank select; the bank keeps alternating across layers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
         r_sw  <= 1'b0;
      end else if (w_accept) begin
         r_idx <= '0;
      end else if (r_state == ST_NEXT) begin
         r_sw <= ~r_sw;
         if (!w_is_last) r_idx <= r_idx + TILE_CNT_WIDTH'(1);
      end
   end

   // Per-tile geometry, refreshed while waiting so it is stable before the start pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tile_loc   <= '0;
         r_tile_in_h  <= '0;
         r_tile_out_h <= '0;
      end else if (r_state == ST_WAIT_BUF) begin
         r_tile_loc[LOC_TOP] <= w_is_first;
         r_tile_loc[LOC_BOT] <= w_is_last;
         r_tile_in_h         <= w_in_h;
         r_tile_out_h        <= w_out_h;
      end
   end

`ifdef TILE_SCH_CTRL_PERF_CNT_EN
   logic [31:0] r_perf;

   // Busy-cycle counter for the current layer, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf <= '0;
      end else if (w_accept) begin
         r_perf <= '0;
      end else if (r_busy && (r_perf != '1)) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_cycles = r_perf;
`endif

   assign ctrl2sch_tile_start = r_start;
   assign stack_switch        = r_sw;
   assign tile_loc            = {2'b00, r_tile_loc};
   assign ksize               = r_ksize;
   assign tile_in_h           = r_tile_in_h;
   assign tile_out_h          = r_tile_out_h;
   assign tile_in_w           = r_in_w;
   assign tile_out_w          = r_out_w;
   assign tile_in_c           = r_in_c;
   assign tile_out_c          = r_out_c;
   assign busy                = r_busy;
   assign layer_done          = r_layer_done;

endmodule

// File: tb/tb_tile_sch_ctrl.sv
// Bench for tile_sch_ctrl: per-tile expectations are queued when a layer is
// launched and popped when the DUT issues a tile-start pulse.
module tb_tile_sch_ctrl;

   localparam int DW = 15;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          layer_start;
   logic [3:0]    cfg_ksize;
   logic [TW-1:0] cfg_num_tiles;
   logic [DW-1:0] cfg_tile_in_h, cfg_last_in_h, cfg_in_w, cfg_out_w, cfg_in_c, cfg_out_c;
   logic          buf_rdy;
   logic          tile_done;
   logic          ctrl2sch_tile_start, stack_switch, busy, layer_done;
   logic [3:0]    tile_loc, ksize;
   logic [DW-1:0] tile_in_h, tile_out_h, tile_in_w, tile_out_w, tile_in_c, tile_out_c;
`ifdef TILE_SCH_CTRL_PERF_CNT_EN
   logic [31:0]   perf_cycles;
`endif

   typedef struct {
      logic [3:0] loc;
      int         in_h;
      int         out_h;
      int         k;
      int         in_w;
      int         out_w;
      int         in_c;
      int         out_c;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   ld_count  = 0;
   int   busy_cyc  = 0;
   bit   exp_sw    = 1'b0;

   tile_sch_ctrl #(
      .DIM_WIDTH      (DW),
      .TILE_CNT_WIDTH (TW)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .layer_start         (layer_start),
      .cfg_ksize           (cfg_ksize),
      .cfg_num_tiles       (cfg_num_tiles),
      .cfg_tile_in_h       (cfg_tile_in_h),
      .cfg_last_in_h       (cfg_last_in_h),
      .cfg_in_w            (cfg_in_w),
      .cfg_out_w           (cfg_out_w),
      .cfg_in_c            (cfg_in_c),
      .cfg_out_c           (cfg_out_c),
      .buf_rdy             (buf_rdy),
      .tile_done           (tile_done),
      .ctrl2sch_tile_start (ctrl2sch_tile_start),
      .stack_switch        (stack_switch),
      .tile_loc            (tile_loc),
      .ksize               (ksize),
      .tile_in_h           (tile_in_h),
      .tile_out_h          (tile_out_h),
      .tile_in_w           (tile_in_w),
      .tile_out_w          (tile_out_w),
      .tile_in_c           (tile_in_c),
      .tile_out_c          (tile_out_c),
      .busy                (busy),
      .layer_done          (layer_done)
`ifdef TILE_SCH_CTRL_PERF_CNT_EN
      ,
      .perf_cycles         (perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model_out_h(input int in_h, input int k, input bit top, input bit bot);
      int r;
      r = in_h - (k - 1) + (top ? k / 2 : 0) + (bot ? k / 2 : 0);
      return (r < 0) ? 0 : r;
   endfunction

   task automatic chk_all_zero();
      chk("rst_busy", busy, 0);
      chk("rst_start", ctrl2sch_tile_start, 0);
      chk("rst_switch", stack_switch, 0);
      chk("rst_layer_done", layer_done, 0);
      chk("rst_tile_loc", tile_loc, 0);
      chk("rst_ksize", ksize, 0);
      chk("rst_in_h", tile_in_h, 0);
      chk("rst_out_h", tile_out_h, 0);
      chk("rst_in_w", tile_in_w, 0);
      chk("rst_out_c", tile_out_c, 0);
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk);
         if (ctrl2sch_tile_start) ok = 1'b1;
      end
   endtask

   // Monitor: scoreboard pops on tile start, layer_done and busy cycles counted
   always @(negedge clk) begin
      if (layer_done) ld_count++;
      if (busy) busy_cyc++;
      if (ctrl2sch_tile_start) begin
         if (sb_q.size() == 0) begin
            chk("extra_start", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("tile_loc", tile_loc, mon_e.loc);
            chk("tile_in_h", tile_in_h, mon_e.in_h);
            chk("tile_out_h", tile_out_h, mon_e.out_h);
            chk("ksize", ksize, mon_e.k);
            chk("tile_in_w", tile_in_w, mon_e.in_w);
            chk("tile_out_w", tile_out_w, mon_e.out_w);
            chk("tile_in_c", tile_in_c, mon_e.in_c);
            chk("tile_out_c", tile_out_c, mon_e.out_c);
         end
      end
   end

   // One layer; stall/spur exercise tile 1 buffer wait and ignored inputs,
   // abort >= 0 resets the DUT in RUN of that tile.
   task automatic run_layer(input int nt, input int k, input int in_h, input int last_h,
                            input int dwell, input int stall, input bit spur, input int abort);
      int   n_eff;
      int   ld0;
      int   nstart;
      bit   ok;
      bit   seen;
      bit   top;
      bit   bot;
      exp_t e;
      n_eff = (nt == 0) ? 1 : nt;
      for (int i = 0; i < n_eff; i++) begin
         if (abort < 0 || i <= abort) begin
            top     = (i == 0);
            bot     = (i == n_eff - 1);
            e.loc   = {2'b00, bot, top};
            e.in_h  = bot ? last_h : in_h;
            e.out_h = model_out_h(e.in_h, k, top, bot);
            e.k     = k;
            e.in_w  = in_h + 3;
            e.out_w = in_h + 1;
            e.in_c  = k * 4;
            e.out_c = k * 8;
            sb_q.push_back(e);
         end
      end
      @(posedge clk); #1;
      cfg_ksize     = 4'(k);
      cfg_num_tiles = TW'(nt);
      cfg_tile_in_h = DW'(in_h);
      cfg_last_in_h = DW'(last_h);
      cfg_in_w      = DW'(in_h + 3);
      cfg_out_w     = DW'(in_h + 1);
      cfg_in_c      = DW'(k * 4);
      cfg_out_c     = DW'(k * 8);
      buf_rdy       = 1'b1;
      layer_start   = 1'b1;
      ld0           = ld_count;
      @(posedge clk); #1;
      layer_start   = 1'b0;
      busy_cyc      = 0;
      chk("busy_on", busy, 1);
      // scramble cfg: the DUT must be using its latched copy
      cfg_ksize     = 4'd9;
      cfg_num_tiles = TW'(5);
      cfg_tile_in_h = DW'(77);
      cfg_last_in_h = DW'(66);
      cfg_in_w      = DW'(1);
      cfg_out_c     = DW'(2);
      seen = 1'b0;
      for (int i = 0; i < n_eff; i++) begin
         if (!seen) begin
            wait_start(ok);
            chk("start_seen", ok, 1);
         end
         seen = 1'b0;
         @(posedge clk);
         repeat (dwell) @(posedge clk);
         #1;
         if (i == abort) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk_all_zero();
            repeat (12) @(negedge clk);
            chk("abort_no_layer_done", ld_count - ld0, 0);
            chk("abort_sb_empty", sb_q.size(), 0);
            exp_sw = 1'b0;
            return;
         end
         if (spur && i == 0) begin
            layer_start = 1'b1;
            @(posedge clk); #1;
            layer_start = 1'b0;
            chk("busy_after_spur_start", busy, 1);
         end
         tile_done = 1'b1;
         if (stall > 0 && i == 0) buf_rdy = 1'b0;
         @(posedge clk); #1;
         tile_done = 1'b0;
         @(posedge clk);
         @(negedge clk);
         exp_sw = ~exp_sw;
         chk("stack_switch", stack_switch, exp_sw);
         if (stall > 0 && i == 0 && n_eff > 1) begin
            @(posedge clk); #1;
            tile_done = 1'b1;
            @(posedge clk); #1;
            tile_done = 1'b0;
            nstart = 0;
            repeat (stall) begin
               @(negedge clk);
               if (ctrl2sch_tile_start) nstart++;
            end
            chk("stall_no_start", nstart, 0);
            @(posedge clk); #1;
            buf_rdy = 1'b1;
            @(negedge clk);
            chk("start_early", ctrl2sch_tile_start, 0);
            @(negedge clk);
            chk("start_after_rdy", ctrl2sch_tile_start, 1);
            seen = 1'b1;
         end
      end
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      chk("layer_idle", ok, 1);
      chk("layer_done_cnt", ld_count - ld0, 1);
`ifdef TILE_SCH_CTRL_PERF_CNT_EN
      chk("perf_cycles", perf_cycles, busy_cyc);
`endif
   endtask

   initial begin
      rst           = 1'b1;
      layer_start   = 1'b0;
      cfg_ksize     = '0;
      cfg_num_tiles = '0;
      cfg_tile_in_h = '0;
      cfg_last_in_h = '0;
      cfg_in_w      = '0;
      cfg_out_w     = '0;
      cfg_in_c      = '0;
      cfg_out_c     = '0;
      buf_rdy       = 1'b0;
      tile_done     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero();

      run_layer(3, 3, 10, 10, 0, 0, 1'b0, -1);  // 3 tiles: loc 1/0/2, out_h 9/8/9
      run_layer(1, 3, 10, 10, 2, 0, 1'b0, -1);  // single tile: loc 3, out_h 10
      run_layer(2, 5, 12, 9, 1, 20, 1'b1, -1);  // buffer stall + ignored inputs
      run_layer(2, 7, 8, 4, 0, 0, 1'b0, -1);    // last out_h = 1
      run_layer(2, 7, 8, 2, 0, 0, 1'b0, -1);    // last out_h clamps to 0
      run_layer(0, 1, 6, 5, 1, 0, 1'b0, -1);    // zero tiles acts as one
      run_layer(3, 3, 10, 10, 1, 0, 1'b0, 1);   // reset in RUN of tile 1
      run_layer(2, 3, 10, 10, 0, 0, 1'b0, -1);  // bank select restarts from 0

      chk("sb_empty_end", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
